// File: rtl/sram_responder.sv
// Cycle-based responder for a 16-bit asynchronous SRAM (1M x 16 part).
// Front door: write/read decode sampled on i_clk, with byte lanes and
// configurable read latency. Back door: full-word load and combinational peek.
// Access counters and a sticky out-of-range flag support self-checking builds.
module sram_responder #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned READ_LAT = 0,
  parameter int unsigned CNT_W    = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [19:0]       SRAM_ADDR,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [15:0]       bd_wdata,
  output logic [15:0]       bd_rdata,
  output logic              bd_drop,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              oob
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0]       mem_q [DEPTH];

  logic              wr_hit;
  logic              rd_hit;
  logic              addr_hi;
  logic              bd_clash;
  logic [ADDR_W-1:0] eff_addr;

  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              oob_q, oob_d;
  logic              bd_drop_q, bd_drop_d;

  // Read-path view presented to the bus drivers (either direct or pipelined)
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              rd_ub_n;
  logic              rd_lb_n;
  logic              hi_en;
  logic              lo_en;

  assign eff_addr = SRAM_ADDR[ADDR_W-1:0];

  if (ADDR_W < 20) begin : g_addr_hi
    assign addr_hi = |SRAM_ADDR[19:ADDR_W];
  end else begin : g_no_addr_hi
    assign addr_hi = 1'b0;
  end

  // Access decode; unknown control levels fall through to idle
  always_comb begin
    wr_hit = 1'b0;
    rd_hit = 1'b0;
    if (SRAM_CE_N == 1'b0 && SRAM_WE_N == 1'b0) begin
      wr_hit = 1'b1;
    end else if (SRAM_CE_N == 1'b0 && SRAM_WE_N == 1'b1 && SRAM_OE_N == 1'b0) begin
      rd_hit = 1'b1;
    end
  end

  assign bd_clash = bd_we && wr_hit && (bd_addr == eff_addr);

  // Memory array: front-door lane writes, back-door word writes; never reset
  always_ff @(posedge i_clk) begin
    if (wr_hit) begin
      if (SRAM_UB_N == 1'b0) mem_q[eff_addr][15:8] <= SRAM_DQ[15:8];
      if (SRAM_LB_N == 1'b0) mem_q[eff_addr][7:0]  <= SRAM_DQ[7:0];
    end
    if (bd_we && !bd_clash) begin
      mem_q[bd_addr] <= bd_wdata;
    end
  end

  assign bd_rdata = mem_q[bd_addr];

  // Next-state for saturating counters, sticky out-of-range and drop pulse
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    oob_d     = oob_q;
    bd_drop_d = bd_clash;
    if (wr_hit && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    if (rd_hit && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if ((wr_hit || rd_hit) && addr_hi) oob_d = 1'b1;
  end

  // Status registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      oob_q     <= 1'b0;
      bd_drop_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      oob_q     <= oob_d;
      bd_drop_q <= bd_drop_d;
    end
  end

  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign oob     = oob_q;
  assign bd_drop = bd_drop_q;

  if (READ_LAT == 0) begin : g_rd_comb
    assign rd_valid = rd_hit;
    assign rd_data  = mem_q[eff_addr];
    assign rd_ub_n  = SRAM_UB_N;
    assign rd_lb_n  = SRAM_LB_N;
  end else begin : g_rd_pipe
    logic [READ_LAT-1:0]       pv_q, pv_d;
    logic [READ_LAT-1:0]       pub_q, pub_d;
    logic [READ_LAT-1:0]       plb_q, plb_d;
    logic [READ_LAT-1:0][15:0] pd_q, pd_d;

    // Shift the read capture down the pipeline, stage 0 takes this edge's read
    always_comb begin
      pv_d     = pv_q;
      pub_d    = pub_q;
      plb_d    = plb_q;
      pd_d     = pd_q;
      pv_d[0]  = rd_hit;
      pub_d[0] = SRAM_UB_N;
      plb_d[0] = SRAM_LB_N;
      pd_d[0]  = mem_q[eff_addr];
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pv_d[i]  = pv_q[i-1];
        pub_d[i] = pub_q[i-1];
        plb_d[i] = plb_q[i-1];
        pd_d[i]  = pd_q[i-1];
      end
    end

    // Pipeline registers; reset drops any in-flight read
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        pv_q  <= '0;
        pub_q <= '1;
        plb_q <= '1;
        pd_q  <= '0;
      end else begin
        pv_q  <= pv_d;
        pub_q <= pub_d;
        plb_q <= plb_d;
        pd_q  <= pd_d;
      end
    end

    // Final-stage data is only presented while the bus still decodes a read
    assign rd_valid = pv_q[READ_LAT-1] && rd_hit;
    assign rd_data  = pd_q[READ_LAT-1];
    assign rd_ub_n  = pub_q[READ_LAT-1];
    assign rd_lb_n  = plb_q[READ_LAT-1];
  end

  // Per-lane output enables, forced off while reset is asserted
  always_comb begin
    hi_en = 1'b0;
    lo_en = 1'b0;
    if (i_rst == 1'b1 && rd_valid) begin
      if (rd_ub_n == 1'b0) hi_en = 1'b1;
      if (rd_lb_n == 1'b0) lo_en = 1'b1;
    end
  end

  assign SRAM_DQ[15:8] = hi_en ? rd_data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = lo_en ? rd_data[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: three instances cover read latency 0/2/3,
// a reduced address width for out-of-range wrap, and a narrow counter for
// saturation. Bus nets are pulled up so an undriven lane reads as all ones.
module tb_sram_responder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ce_n;
  logic        we_n, oe_n, ub_n, lb_n;
  logic [19:0] addr;
  logic        drv;
  logic [15:0] wdat;
  logic [2:0]  bd_we;
  logic [19:0] bd_addr;
  logic [15:0] bd_wdata;

  tri1  [15:0] dq0, dq2, dq3;

  logic [15:0] bdr0, bdr2, bdr3;
  logic        drop0, drop2, drop3;
  logic        oob0, oob2, oob3;
  logic [19:0] wc0, rc0, wc3, rc3;
  logic [2:0]  wc2, rc2;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] exp2 [6];
  logic [19:0] adr2 [6];
  logic        oe2  [6];

  always #5 clk = ~clk;

  assign dq0 = drv ? wdat : 16'hzzzz;
  assign dq2 = drv ? wdat : 16'hzzzz;
  assign dq3 = drv ? wdat : 16'hzzzz;

  sram_responder #(.ADDR_W(16), .READ_LAT(0), .CNT_W(20)) u0 (
    .i_clk(clk), .i_rst(rst_n), .SRAM_ADDR(addr), .SRAM_DQ(dq0),
    .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .bd_we(bd_we[0]), .bd_addr(bd_addr[15:0]), .bd_wdata(bd_wdata),
    .bd_rdata(bdr0), .bd_drop(drop0), .wr_cnt(wc0), .rd_cnt(rc0), .oob(oob0));

  sram_responder #(.ADDR_W(16), .READ_LAT(2), .CNT_W(3)) u2 (
    .i_clk(clk), .i_rst(rst_n), .SRAM_ADDR(addr), .SRAM_DQ(dq2),
    .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .bd_we(bd_we[1]), .bd_addr(bd_addr[15:0]), .bd_wdata(bd_wdata),
    .bd_rdata(bdr2), .bd_drop(drop2), .wr_cnt(wc2), .rd_cnt(rc2), .oob(oob2));

  sram_responder #(.ADDR_W(20), .READ_LAT(3), .CNT_W(20)) u3 (
    .i_clk(clk), .i_rst(rst_n), .SRAM_ADDR(addr), .SRAM_DQ(dq3),
    .SRAM_CE_N(ce_n[2]), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .bd_we(bd_we[2]), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .bd_rdata(bdr3), .bd_drop(drop3), .wr_cnt(wc3), .rd_cnt(rc3), .oob(oob3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ce_n  = '1;
    we_n  = 1'b1;
    oe_n  = 1'b1;
    ub_n  = 1'b1;
    lb_n  = 1'b1;
    drv   = 1'b0;
    wdat  = '0;
    bd_we = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int unsigned idx, input logic [19:0] a, input logic [15:0] d);
    bd_we[idx] = 1'b1;
    bd_addr    = a;
    bd_wdata   = d;
    tick();
    idle();
  endtask

  task automatic fwrite(input int unsigned idx, input logic [19:0] a, input logic [15:0] d,
                        input logic ub, input logic lb);
    ce_n[idx] = 1'b0;
    we_n      = 1'b0;
    addr      = a;
    drv       = 1'b1;
    wdat      = d;
    ub_n      = ub;
    lb_n      = lb;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    addr     = '0;
    bd_addr  = '0;
    bd_wdata = '0;
    adr2 = '{20'h0, 20'h1, 20'h2, 20'h3, 20'h3, 20'h3};
    oe2  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp2 = '{16'hFFFF, 16'hFFFF, 16'h0010, 16'h0011, 16'h0012, 16'hFFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_cnt", 32'(wc0), 32'd0);
    chk("rst_rd_cnt", 32'(rc0), 32'd0);
    chk("rst_oob", 32'(oob0), 32'd0);
    chk("rst_bd_drop", 32'(drop0), 32'd0);
    chk("rst_dq0_z", 32'(dq0), 32'h0000FFFF);
    rst_n = 1'b1;
    tick();

    // Latency 0 write then same-cycle read
    fwrite(0, 20'h00005, 16'hBEEF, 1'b0, 1'b0);
    ce_n[0] = 1'b0; oe_n = 1'b0; addr = 20'h5; ub_n = 1'b0; lb_n = 1'b0;
    @(negedge clk);
    chk("lat0_read", 32'(dq0), 32'h0000BEEF);
    tick();
    idle();
    chk("lat0_wr_cnt", 32'(wc0), 32'd1);
    chk("lat0_rd_cnt", 32'(rc0), 32'd1);

    // Byte lanes
    preload(0, 20'h9, 16'h1234);
    fwrite(0, 20'h9, 16'hABCD, 1'b0, 1'b1);
    bd_addr = 20'h9;
    #1;
    chk("lane_write_ub", 32'(bdr0), 32'h0000AB34);
    ce_n[0] = 1'b0; oe_n = 1'b0; addr = 20'h9; ub_n = 1'b1; lb_n = 1'b0;
    @(negedge clk);
    chk("lane_read_lb", 32'(dq0), 32'h0000FF34);
    tick();
    idle();
    chk("lane_wr_cnt", 32'(wc0), 32'd2);
    chk("lane_rd_cnt", 32'(rc0), 32'd2);

    // Latency 2 burst with early OE_N release
    for (int unsigned i = 0; i < 4; i++) preload(1, 20'(i), 16'(16'h10 + i));
    for (int k = 0; k < 6; k++) begin
      ce_n[1] = 1'b0; we_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
      addr = adr2[k];
      oe_n = oe2[k];
      @(negedge clk);
      chk($sformatf("lat2_c%0d", k), 32'(dq2), 32'(exp2[k]));
      tick();
    end
    idle();
    chk("lat2_rd_cnt", 32'(rc2), 32'd5);
    ce_n[1] = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0; addr = 20'h0;
    repeat (4) tick();
    idle();
    chk("rd_cnt_saturate", 32'(rc2), 32'd7);
    chk("lat2_wr_cnt", 32'(wc2), 32'd0);

    // Loopback-style sequence through the front door
    for (int unsigned i = 0; i < 4; i++) fwrite(0, 20'(i), 16'(i + 1), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      ce_n[0] = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0; addr = 20'(i);
      @(negedge clk);
      chk($sformatf("loop_rd%0d", i), 32'(dq0), 32'(i + 1));
      tick();
    end
    idle();
    chk("loop_wr_cnt", 32'(wc0), 32'd6);
    chk("loop_rd_cnt", 32'(rc0), 32'd6);

    // Same-edge collision: front door wins, drop pulses once
    ce_n[0] = 1'b0; we_n = 1'b0; addr = 20'h20; drv = 1'b1; wdat = 16'h5555;
    ub_n = 1'b0; lb_n = 1'b0;
    bd_we[0] = 1'b1; bd_addr = 20'h20; bd_wdata = 16'hAAAA;
    @(negedge clk);
    chk("drop_before", 32'(drop0), 32'd0);
    tick();
    idle();
    chk("drop_pulse", 32'(drop0), 32'd1);
    chk("collide_mem", 32'(bdr0), 32'h00005555);
    tick();
    chk("drop_clear", 32'(drop0), 32'd0);

    // Different-address backdoor write proceeds
    ce_n[0] = 1'b0; we_n = 1'b0; addr = 20'h21; drv = 1'b1; wdat = 16'h1111;
    ub_n = 1'b0; lb_n = 1'b0;
    bd_we[0] = 1'b1; bd_addr = 20'h22; bd_wdata = 16'h2222;
    tick();
    idle();
    chk("nodrop", 32'(drop0), 32'd0);
    #1;
    chk("bd_write_ok", 32'(bdr0), 32'h00002222);
    bd_addr = 20'h21;
    #1;
    chk("fd_write_ok", 32'(bdr0), 32'h00001111);

    // Out-of-range address wraps and sets sticky flag
    chk("oob_pre", 32'(oob0), 32'd0);
    fwrite(0, 20'h10020, 16'h7777, 1'b0, 1'b0);
    bd_addr = 20'h20;
    #1;
    chk("oob_wrap_mem", 32'(bdr0), 32'h00007777);
    chk("oob_set", 32'(oob0), 32'd1);
    tick();
    tick();
    chk("oob_sticky", 32'(oob0), 32'd1);
    chk("oob_wr_cnt", 32'(wc0), 32'd9);

    // Latency 3 burst interrupted by reset
    preload(2, 20'h80040, 16'hC0DE);
    preload(2, 20'h80041, 16'hC0DF);
    for (int k = 0; k < 4; k++) begin
      ce_n[2] = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
      addr = 20'h80040;
      @(negedge clk);
      chk($sformatf("lat3_c%0d", k), 32'(dq3), (k < 3) ? 32'h0000FFFF : 32'h0000C0DE);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rst_async_dq", 32'(dq3), 32'h0000FFFF);
    chk("rst_rd_cnt3", 32'(rc3), 32'd0);
    chk("rst_wr_cnt0", 32'(wc0), 32'd0);
    chk("rst_oob0", 32'(oob0), 32'd0);
    bd_addr = 20'h80041;
    #1;
    chk("rst_mem3_kept", 32'(bdr3), 32'h0000C0DF);
    bd_addr = 20'h20;
    #1;
    chk("rst_mem0_kept", 32'(bdr0), 32'h00007777);
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      ce_n[2] = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
      addr = 20'h80041;
      @(negedge clk);
      chk($sformatf("post_rst_c%0d", k), 32'(dq3), (k < 3) ? 32'h0000FFFF : 32'h0000C0DF);
      tick();
    end
    idle();
    chk("post_rst_rd_cnt", 32'(rc3), 32'd4);
    chk("full_width_no_oob", 32'(oob3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
